// File: rtl/x1t_modereg_bank.sv
// Bank of NREG mode/control registers with readback, per-register reset values,
// and optional commit deferred to the next vertical-blank rising edge.
module x1t_modereg_bank #(
  parameter int                 NREG      = 4,
  parameter int                 DW        = 8,
  parameter int                 AW        = 2,
  parameter logic [NREG*DW-1:0] RESET_VAL = '0,
  parameter logic [NREG-1:0]    SYNC_MASK = NREG'(4'b0010),
  parameter logic [NREG-1:0]    RD_MASK   = '1
) (
  input  logic               CLK,
  input  logic               I_RESET_N,
  input  logic [DW-1:0]      I_D,
  output logic [DW-1:0]      O_D,
  output logic               O_DOE,
  input  logic               I_WR,
  input  logic               I_RD,
  input  logic               I_CS,
  input  logic [AW-1:0]      I_A,
  input  logic               I_VBLANK,
  output logic [NREG*DW-1:0] O_REGS,
  output logic [NREG-1:0]    O_PEND,
  output logic [NREG-1:0]    O_CHG
);

  logic [DW-1:0] shadow_q [NREG];
  logic [DW-1:0] shadow_d [NREG];
  logic [DW-1:0] active_q [NREG];
  logic [DW-1:0] active_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] chg_q, chg_d;
  logic vbl_prev_q, vbl_prev_d;
  logic vbl_rise;
  logic wr_en;

  // Commit of pending values uses the shadow as it stood before this edge,
  // so a write landing on the vblank edge stays pending for the next one.
  always_comb begin
    vbl_rise   = I_VBLANK & ~vbl_prev_q;
    vbl_prev_d = I_VBLANK;
    wr_en      = I_CS & I_WR;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pend_d     = pend_q;
    chg_d      = '0;
    for (int i = 0; i < NREG; i++) begin
      if (vbl_rise && pend_q[i]) begin
        active_d[i] = shadow_q[i];
        pend_d[i]   = 1'b0;
      end
      if (wr_en && (I_A == AW'(i))) begin
        shadow_d[i] = I_D;
        if (SYNC_MASK[i]) begin
          pend_d[i] = 1'b1;
        end else begin
          active_d[i] = I_D;
        end
      end
      chg_d[i] = (active_d[i] != active_q[i]);
    end
  end

  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= RESET_VAL[i*DW +: DW];
        active_q[i] <= RESET_VAL[i*DW +: DW];
      end
      pend_q     <= '0;
      chg_q      <= '0;
      vbl_prev_q <= 1'b1;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      chg_q      <= chg_d;
      vbl_prev_q <= vbl_prev_d;
    end
  end

  // Readback returns the last written (shadow) value, not the applied one.
  always_comb begin
    O_D   = '0;
    O_DOE = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (I_CS && I_RD && (I_A == AW'(i)) && RD_MASK[i]) begin
        O_D   = shadow_q[i];
        O_DOE = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign O_REGS[g*DW +: DW] = active_q[g];
  end

  assign O_PEND = pend_q;
  assign O_CHG  = chg_q;

endmodule

// File: tb/tb_x1t_modereg_bank.sv
// Self-checking bench for x1t_modereg_bank: directed scenarios plus randomized
// traffic compared against a behavioural model of the register bank.
module tb_x1t_modereg_bank;
  localparam int          NREG      = 4;
  localparam int          DW        = 8;
  localparam int          AW        = 2;
  localparam logic [31:0] RESET_VAL = 32'hC35A_0000;
  localparam logic [3:0]  SYNC_MASK = 4'b1010;
  localparam logic [3:0]  RD_MASK   = 4'b0111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_d = '0;
  logic [DW-1:0] o_d;
  logic          o_doe;
  logic          i_wr = 1'b0;
  logic          i_rd = 1'b0;
  logic          i_cs = 1'b0;
  logic [AW-1:0] i_a = '0;
  logic          i_vblank = 1'b0;
  logic [31:0]   o_regs;
  logic [3:0]    o_pend;
  logic [3:0]    o_chg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_shadow [4];
  logic [7:0] m_active [4];
  logic [3:0] m_pend;
  logic [3:0] m_chg;
  logic       m_vbl_prev;

  logic [7:0] obs_d;
  logic       obs_doe;

  x1t_modereg_bank #(
    .NREG(NREG), .DW(DW), .AW(AW), .RESET_VAL(RESET_VAL),
    .SYNC_MASK(SYNC_MASK), .RD_MASK(RD_MASK)
  ) dut (
    .CLK(clk), .I_RESET_N(rst_n), .I_D(i_d), .O_D(o_d), .O_DOE(o_doe),
    .I_WR(i_wr), .I_RD(i_rd), .I_CS(i_cs), .I_A(i_a), .I_VBLANK(i_vblank),
    .O_REGS(o_regs), .O_PEND(o_pend), .O_CHG(o_chg)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_regs();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_active[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = RESET_VAL[i*8 +: 8];
      m_active[i] = RESET_VAL[i*8 +: 8];
    end
    m_pend     = '0;
    m_chg      = '0;
    m_vbl_prev = 1'b1;
  endtask

  // One bus cycle: drive, check combinational readback, advance model, check state.
  task automatic apply_stimulus(input logic cs, input logic wr, input logic rd,
                                input logic [1:0] a, input logic [7:0] d, input logic vbl);
    logic [7:0] old_active [4];
    logic [7:0] exp_d;
    logic       exp_doe;
    int         ai;
    i_cs = cs; i_wr = wr; i_rd = rd; i_a = a; i_d = d; i_vblank = vbl;
    #1;
    ai      = int'(a);
    exp_doe = cs && rd && (ai < NREG) && RD_MASK[ai];
    exp_d   = exp_doe ? m_shadow[ai] : 8'h00;
    obs_d   = o_d;
    obs_doe = o_doe;
    check_output("rd_doe", {63'b0, o_doe}, {63'b0, exp_doe});
    check_output("rd_data", {56'b0, o_d}, {56'b0, exp_d});
    old_active = m_active;
    if (vbl && !m_vbl_prev) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i]) begin
          m_active[i] = m_shadow[i];
          m_pend[i]   = 1'b0;
        end
      end
    end
    if (cs && wr && ai < NREG) begin
      m_shadow[ai] = d;
      if (SYNC_MASK[ai]) m_pend[ai] = 1'b1;
      else               m_active[ai] = d;
    end
    for (int i = 0; i < 4; i++) m_chg[i] = (m_active[i] != old_active[i]);
    m_vbl_prev = vbl;
    @(posedge clk);
    #1;
    check_output("regs", {32'b0, o_regs}, {32'b0, model_regs()});
    check_output("pend", {60'b0, o_pend}, {60'b0, m_pend});
    check_output("chg", {60'b0, o_chg}, {60'b0, m_chg});
  endtask

  initial begin
    model_reset();
    i_vblank = 1'b1;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_regs", {32'b0, o_regs}, {32'b0, RESET_VAL});
    check_output("reset_pend", {60'b0, o_pend}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 0, 0, 2'd0, 8'h00, 1);
      check_output("reset_nochg", {60'b0, o_chg}, 64'd0);
    end

    apply_stimulus(1, 1, 0, 2'd0, 8'hA5, 0);
    check_output("imm_val", {56'b0, o_regs[7:0]}, 64'hA5);
    check_output("imm_chg", {60'b0, o_chg}, 64'h1);
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 0);
    check_output("imm_chg_clear", {60'b0, o_chg}, 64'h0);
    apply_stimulus(1, 1, 0, 2'd0, 8'hA5, 0);
    check_output("same_nochg", {60'b0, o_chg}, 64'h0);

    apply_stimulus(1, 1, 0, 2'd1, 8'h3C, 0);
    check_output("sync_held", {56'b0, o_regs[15:8]}, 64'h00);
    check_output("sync_pend", {63'b0, o_pend[1]}, 64'h1);
    apply_stimulus(1, 0, 1, 2'd1, 8'h00, 0);
    check_output("readback_doe", {63'b0, obs_doe}, 64'h1);
    check_output("readback_data", {56'b0, obs_d}, 64'h3C);
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 1);
    check_output("vbl_commit", {56'b0, o_regs[15:8]}, 64'h3C);
    check_output("vbl_pend_clr", {63'b0, o_pend[1]}, 64'h0);
    check_output("vbl_chg", {60'b0, o_chg}, 64'h2);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, 0, 0, 2'd0, 8'h00, 1);
      check_output("vbl_hold_nochg", {60'b0, o_chg}, 64'h0);
    end

    apply_stimulus(1, 1, 0, 2'd1, 8'h11, 0);
    apply_stimulus(1, 1, 0, 2'd1, 8'h22, 1);
    check_output("edge_wr_old", {56'b0, o_regs[15:8]}, 64'h11);
    check_output("edge_wr_pend", {63'b0, o_pend[1]}, 64'h1);
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 0);
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 1);
    check_output("edge_wr_new", {56'b0, o_regs[15:8]}, 64'h22);

    apply_stimulus(1, 0, 1, 2'd3, 8'h00, 0);
    check_output("rdmask_doe", {63'b0, obs_doe}, 64'h0);
    check_output("rdmask_data", {56'b0, obs_d}, 64'h0);
    apply_stimulus(0, 1, 0, 2'd0, 8'h77, 0);
    check_output("no_cs", {56'b0, o_regs[7:0]}, 64'hA5);

    apply_stimulus(1, 1, 0, 2'd1, 8'h99, 0);
    check_output("pre_rst_pend", {63'b0, o_pend[1]}, 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_regs", {32'b0, o_regs}, {32'b0, RESET_VAL});
    check_output("async_rst_pend", {60'b0, o_pend}, 64'h0);
    check_output("async_rst_chg", {60'b0, o_chg}, 64'h0);
    model_reset();
    i_cs = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_vblank = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 0);
    apply_stimulus(0, 0, 0, 2'd0, 8'h00, 1);
    check_output("post_rst_nocommit", {32'b0, o_regs}, {32'b0, RESET_VAL});
    check_output("post_rst_nochg", {60'b0, o_chg}, 64'h0);

    for (int k = 0; k < 400; k++) begin
      logic vbl_next;
      vbl_next = ($urandom_range(0, 5) == 0) ? ~i_vblank : i_vblank;
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 255)), vbl_next);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
